// File: rtl/frame_sequencer.sv
// Multi-channel frame load sequencer: on a start command edge, waits for all enabled
// reader/writer channels to be ready and issues one-cycle load strobes per frame.
module frame_sequencer #(
  parameter int              NCH       = 2,
  parameter int              CNT_W     = 16,
  parameter int              TO_W      = 24,
  parameter logic [TO_W-1:0] TIMEOUT   = 24'hFFFFFF,
  parameter logic [31:0]     CMD_START = 32'h1,
  parameter logic [31:0]     CMD_STOP  = 32'h2
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic [31:0]      mmio_cmd,
  input  logic [NCH-1:0]   chan_en,
  input  logic [CNT_W-1:0] frame_count,
  input  logic [NCH-1:0]   rd_frame_ready,
  input  logic [NCH-1:0]   wr_frame_ready,
  output logic [NCH-1:0]   load_addr,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [CNT_W-1:0] frames_done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_LOAD = 2'd2, S_DRAIN = 2'd3} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1'b1);

  state_e           state_q, state_d;
  logic             start_q, stop_q, stop_pend_q, stop_pend_d;
  logic [NCH-1:0]   en_l_q, en_l_d, load_addr_q, load_addr_d;
  logic [CNT_W-1:0] fc_l_q, fc_l_d, frames_done_q, frames_done_d, fd_inc;
  logic             done_q, done_d, timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             match_start, match_stop, start_edge, stop_edge, all_rdy, to_hit;

  always_comb begin
    match_start   = (mmio_cmd == CMD_START);
    match_stop    = (mmio_cmd == CMD_STOP);
    start_edge    = match_start & ~start_q;
    stop_edge     = match_stop & ~stop_q;
    all_rdy       = &((rd_frame_ready & wr_frame_ready) | ~en_l_q);
    to_hit        = (TIMEOUT != '0) && (to_cnt_q == TO_LAST);
    fd_inc        = frames_done_q + CNT_W'(1);

    state_d       = state_q;
    en_l_d        = en_l_q;
    fc_l_d        = fc_l_q;
    frames_done_d = frames_done_q;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    stop_pend_d   = stop_pend_q | (stop_edge && state_q != S_IDLE);

    case (state_q)
      S_IDLE: if (start_edge && |chan_en) begin
        en_l_d        = chan_en;
        fc_l_d        = frame_count;
        frames_done_d = '0;
        done_d        = 1'b0;
        timeout_err_d = 1'b0;
        stop_pend_d   = 1'b0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (stop_pend_q)  state_d = S_DRAIN;
        else if (all_rdy) state_d = S_LOAD;
        else if (to_hit) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_LOAD: begin
        frames_done_d = fd_inc;
        if (stop_pend_q || (fc_l_q != '0 && fd_inc == fc_l_q)) state_d = S_DRAIN;
        else                                                   state_d = S_WAIT;
      end
      S_DRAIN: begin
        if (all_rdy) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (to_hit) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_pend_d = 1'b0;

    // Saturating wait counter, restarted on every state change
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) to_cnt_d = '0;
    else if ((state_q == S_WAIT || state_q == S_DRAIN) && to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);

    load_addr_d = (state_d == S_LOAD) ? en_l_d : '0;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      stop_pend_q   <= 1'b0;
      en_l_q        <= '0;
      fc_l_q        <= '0;
      frames_done_q <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
      load_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= match_start;
      stop_q        <= match_stop;
      stop_pend_q   <= stop_pend_d;
      en_l_q        <= en_l_d;
      fc_l_q        <= fc_l_d;
      frames_done_q <= frames_done_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
      load_addr_q   <= load_addr_d;
    end
  end

  assign load_addr   = load_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign frames_done = frames_done_q;
  assign state_dbg   = {1'b0, state_q};

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: two channels, 16-cycle timeout, buffer model that
// drops ready for 4 cycles after each accepted strobe.
module tb_frame_sequencer;
  logic        fclk = 1'b0;
  logic        rst;
  logic [31:0] mmio_cmd;
  logic [1:0]  chan_en, rd_ok, wr_ok, pend;
  logic [15:0] frame_count;
  logic [1:0]  rd_frame_ready, wr_frame_ready, load_addr;
  logic        busy, done, timeout_err;
  logic [15:0] frames_done;
  logic [2:0]  state_dbg;

  int errors = 0, checks = 0;
  int strobe_cnt = 0;
  logic [1:0] or_strobes = '0, last_strobe = '0;
  int cnt [2] = '{0, 0};

  frame_sequencer #(.NCH(2), .CNT_W(16), .TO_W(24), .TIMEOUT(24'd16)) dut (
    .fclk(fclk), .rst(rst), .mmio_cmd(mmio_cmd), .chan_en(chan_en), .frame_count(frame_count),
    .rd_frame_ready(rd_frame_ready), .wr_frame_ready(wr_frame_ready), .load_addr(load_addr),
    .busy(busy), .done(done), .timeout_err(timeout_err), .frames_done(frames_done),
    .state_dbg(state_dbg));

  always #5 fclk = ~fclk;

  // Buffer model: ready drops the cycle after a strobe, for 4 cycles
  always @(posedge fclk) begin
    for (int i = 0; i < 2; i++) begin
      if (load_addr[i]) cnt[i] <= 4;
      else if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
    end
    if (load_addr != '0) begin
      strobe_cnt  <= strobe_cnt + 1;
      or_strobes  <= or_strobes | load_addr;
      last_strobe <= load_addr;
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < 2; i++) pend[i] = (cnt[i] != 0);
  end
  assign rd_frame_ready = rd_ok & ~pend;
  assign wr_frame_ready = wr_ok & ~pend;

  task automatic step(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin step(1); k++; end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_pulse();
    mmio_cmd = 32'h0; step(1);
    mmio_cmd = 32'h1;
  endtask

  initial begin
    int k, base;
    rst = 1'b1; mmio_cmd = '0; chan_en = '0; frame_count = '0; rd_ok = '0; wr_ok = '0;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_terr", {31'd0, timeout_err}, 0);
    check("rst_fdone", {16'd0, frames_done}, 0);
    check("rst_state", {29'd0, state_dbg}, 0);
    check("rst_load", {30'd0, load_addr}, 0);

    // Three-frame run on both channels; first-transaction latency
    chan_en = 2'b11; frame_count = 16'd3; rd_ok = 2'b11; wr_ok = 2'b11;
    start_pulse();
    step(1); check("a_state_wait", {29'd0, state_dbg}, 1);
    step(1); check("a_first_load", {30'd0, load_addr}, 2'b11);
    step(1); check("a_fdone_1", {16'd0, frames_done}, 1);
    wait_idle("a_idle", 100);
    check("a_strobes", strobe_cnt, 3);
    check("a_last", {30'd0, last_strobe}, 2'b11);
    check("a_fdone", {16'd0, frames_done}, 3);
    check("a_done", {31'd0, done}, 1);
    // Held start level must not retrigger
    base = strobe_cnt;
    step(10);
    check("a_hold_busy", {31'd0, busy}, 0);
    check("a_hold_strobes", strobe_cnt, base);

    // Reset during LOAD
    frame_count = 16'd0;
    start_pulse();
    step(2); check("b_in_load", {30'd0, load_addr}, 2'b11);
    rst = 1'b1; mmio_cmd = 32'h0;
    step(1);
    check("b_load_off", {30'd0, load_addr}, 0);
    check("b_busy", {31'd0, busy}, 0);
    check("b_fdone", {16'd0, frames_done}, 0);
    check("b_state", {29'd0, state_dbg}, 0);
    rst = 1'b0;
    base = strobe_cnt;
    step(12);
    check("b_no_strobe", strobe_cnt, base);

    // Channel 1 masked off with its readies held low
    chan_en = 2'b01; frame_count = 16'd2; rd_ok = 2'b01; wr_ok = 2'b01;
    base = strobe_cnt; or_strobes = '0;
    start_pulse();
    step(1);
    wait_idle("c_idle", 100);
    check("c_strobes", strobe_cnt - base, 2);
    check("c_mask", {30'd0, or_strobes}, 2'b01);
    check("c_fdone", {16'd0, frames_done}, 2);
    check("c_done", {31'd0, done}, 1);

    // Continuous mode, stop after the fifth strobe
    chan_en = 2'b11; frame_count = 16'd0; rd_ok = 2'b11; wr_ok = 2'b11;
    base = strobe_cnt;
    start_pulse();
    k = 0;
    while (strobe_cnt - base < 5 && k < 200) begin step(1); k++; end
    check("d_five", strobe_cnt - base, 5);
    mmio_cmd = 32'h2;
    wait_idle("d_idle", 100);
    check("d_no_sixth", strobe_cnt - base, 5);
    check("d_fdone", {16'd0, frames_done}, 5);
    check("d_done", {31'd0, done}, 1);
    start_pulse();
    step(1); check("d_restart", {29'd0, state_dbg}, 1);
    mmio_cmd = 32'h2;
    wait_idle("d_restop", 100);

    // Writer 0 stuck low: timeout 16 cycles after WAIT entry
    wr_ok = 2'b10; base = strobe_cnt;
    start_pulse();
    step(1); check("e_wait", {29'd0, state_dbg}, 1);
    k = 0;
    while (busy && k < 40) begin step(1); k++; end
    check("e_cycles", k, 16);
    check("e_terr", {31'd0, timeout_err}, 1);
    check("e_done", {31'd0, done}, 0);
    check("e_no_load", strobe_cnt, base);

    // Empty channel mask: start ignored
    rst = 1'b1; step(1); rst = 1'b0;
    chan_en = 2'b00; wr_ok = 2'b11;
    start_pulse();
    step(3);
    check("f_busy", {31'd0, busy}, 0);
    check("f_state", {29'd0, state_dbg}, 0);
    check("f_done", {31'd0, done}, 0);
    check("f_terr", {31'd0, timeout_err}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Multi-channel frame load sequencer between the MMIO command register and the DRAM reader/writer buffers. It watches the MMIO command word and waits until every enabled reader and writer channel reports frame-ready. It then issues a synchronous one-cycle address-load strobe to all enabled channels, repeating for a programmed number of frames or continuously until a stop command. It supersedes the fixed single-shot, single-pair load FSM in the top level with a parametrised channel count, frame counting, graceful stop and a ready-wait timeout.

## Interface
Parameters:
- NCH, 2, number of reader/writer channel pairs (1..16)
- CNT_W, 16, width of frame count and frames-done counter
- TO_W, 24, width of the ready-wait timeout counter
- TIMEOUT, 24'hFFFFFF, wait cycles before the timeout error; 0 disables the timeout
- CMD_START, 32'h1, command value that starts a run
- CMD_STOP, 32'h2, command value that requests a stop

Ports:
- fclk  in  1  clock; one clock domain. Reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high
- mmio_cmd  in  32  MMIO command word (level)
- chan_en  in  NCH  channel enable mask, latched at start
- frame_count  in  CNT_W  frames to run, latched at start; 0 = continuous
- rd_frame_ready  in  NCH  per-channel reader ready
- wr_frame_ready  in  NCH  per-channel writer ready
- load_addr  out  NCH  one-cycle frame-valid strobe per channel
- busy  out  1  high when state != IDLE
- done  out  1  sticky; run ended normally
- timeout_err  out  1  sticky; run aborted on timeout
- frames_done  out  CNT_W  frames issued in the current or last run
- state_dbg  out  3  current FSM state encoding

## Operation
- Command decode:
  - match_start = (mmio_cmd == CMD_START), registered as start_q.
  - start_edge = match_start & ~start_q. stop_edge is formed the same way from CMD_STOP.
  - A level held on mmio_cmd never retriggers a run.
- States: IDLE=0, WAIT=1, LOAD=2, DRAIN=3.
- IDLE:
  - On start_edge with chan_en != 0: latch en_l = chan_en and fc_l = frame_count. Clear frames_done, done, timeout_err and stop_pend. Go to WAIT.
  - On start_edge with chan_en == 0: ignore it; stay in IDLE with no flag change.
- all_rdy = &((rd_frame_ready & wr_frame_ready) | ~en_l).
- WAIT:
  - If stop_pend: go to DRAIN.
  - Else if all_rdy: go to LOAD.
  - Else if TIMEOUT != 0 and to_cnt == TIMEOUT-1: set timeout_err and go to IDLE.
- LOAD:
  - load_addr = en_l for exactly this cycle; frames_done increments by 1.
  - Go to DRAIN if stop_pend, or if fc_l != 0 and frames_done+1 == fc_l. Otherwise go to WAIT.
- DRAIN:
  - No strobes are issued.
  - If all_rdy: set done and go to IDLE.
  - Timeout is handled as in WAIT: set timeout_err and go to IDLE. done stays 0.
- stop_pend:
  - Set by stop_edge in WAIT, LOAD or DRAIN; cleared when the FSM enters IDLE.
  - stop_edge in IDLE has no effect.
- start_edge outside IDLE is ignored.
- to_cnt clears on every state change and counts in WAIT and DRAIN only. It saturates and never wraps.
- frames_done is CNT_W-bit and wraps modulo 2^CNT_W in continuous mode. With fc_l != 0 it stops at fc_l.
- Connected buffers drop frame_ready in the cycle after accepting load_addr. The first WAIT cycle after LOAD therefore sees the updated ready.

## Timing
- Reset values: state=IDLE; load_addr=0, busy=0, done=0, timeout_err=0, frames_done=0, state_dbg=0. start_q, stop_q and stop_pend are 0.
- Reset mid-run aborts immediately; no strobe is issued in the reset cycle or the cycle after it.
- mmio_cmd first equal to CMD_START at edge t: start_edge is combinational in cycle t, and state=WAIT at t+1.
- If all_rdy is already high, load_addr is high in cycle t+2, and frames_done shows the new value from t+3.
- Steady-state frame rate is one LOAD per 2 cycles minimum (LOAD then WAIT).
- done and timeout_err assert in the same cycle busy falls.
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.

## Test plan
- Reset during LOAD -> load_addr=0 the next cycle; all outputs at their reset values; no further strobes until a new start edge.
- NCH=2, chan_en=2'b11, frame_count=3, readies pulse low 4 cycles after each strobe -> exactly 3 load_addr=2'b11 strobes; frames_done=3; done=1; busy=0.
- chan_en=2'b01, channel 1 readies held 0, frame_count=2 -> strobes are 2'b01 only and channel 1 is ignored; done=1.
- frame_count=0, stop written after the 5th strobe -> no 6th strobe; FSM drains until ready, then done=1 with frames_done=5. Holding CMD_START afterwards produces no restart; rewriting 0 then CMD_START does restart.
- TIMEOUT=16, wr_frame_ready[0] stuck 0 -> timeout_err=1 with busy falling 16 cycles after WAIT entry; done=0; load_addr never asserted.
- chan_en=0 with a start edge -> stays in IDLE; busy=0, done=0, timeout_err=0.
